// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin grant controller.
// Seven-segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_BUSY
  } arb_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_D0    = 7'b1000000;
  localparam logic [6:0] SEG_D1    = 7'b1111001;
  localparam logic [6:0] SEG_D2    = 7'b0100100;
  localparam logic [6:0] SEG_D3    = 7'b0110000;
  localparam logic [6:0] SEG_D4    = 7'b0011001;
  localparam logic [6:0] SEG_D5    = 7'b0010010;
  localparam logic [6:0] SEG_D6    = 7'b0000010;
  localparam logic [6:0] SEG_D7    = 7'b1111000;

endpackage

// File: rtl/idx_seg7.sv
// Combinational decoder from a 3-bit winner index to an active-low 7-segment digit.
// The display is blanked whenever the index is not valid.
module idx_seg7
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             valid,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (valid) begin
      case (idx)
        3'd0:    seg = SEG_D0;
        3'd1:    seg = SEG_D1;
        3'd2:    seg = SEG_D2;
        3'd3:    seg = SEG_D3;
        3'd4:    seg = SEG_D4;
        3'd5:    seg = SEG_D5;
        3'd6:    seg = SEG_D6;
        default: seg = SEG_D7;
      endcase
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// 8-input round-robin arbiter; a winner holds the grant until it drops its request.
// Define ARB_TIMEOUT_EN to force preemption after MAX_HOLD consecutive grant cycles.
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt,
  output logic [6:0]       seg
);

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_grant_ctrl: MAX_HOLD must be at least 2");
  end

  // Returns {found, index} of the first set bit of r scanning p, p+1, ... modulo NREQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] k;
    rr_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = p + IDX_W'(i);
      if (r[k]) rr_pick = {1'b1, k};
    end
  endfunction

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [IDX_W:0]   pick;
  logic [IDX_W-1:0] new_idx;
  logic             grant_now, drop_now;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;
  logic [IDX_W:0]    pick_ex;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    grant_now = 1'b0;
    drop_now  = 1'b0;
    pick      = rr_pick(req, ptr_q);
    new_idx   = pick[IDX_W-1:0];
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
    // Preemption search skips the current holder even though it still requests.
    pick_ex   = rr_pick(req & ~gnt_q, ptr_q);
`endif

    unique case (state_q)
      ST_IDLE: grant_now = en && pick[IDX_W];
      ST_BUSY: begin
        if (!en) begin
          drop_now = 1'b1;
        end else if (!req[idx_q]) begin
          grant_now = pick[IDX_W];
          drop_now  = !pick[IDX_W];
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (hold_q == HOLD_MAX) begin
            if (pick_ex[IDX_W]) begin
              grant_now = 1'b1;
              new_idx   = pick_ex[IDX_W-1:0];
              preempt_d = 1'b1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
      end
      default: drop_now = 1'b1;
    endcase

    if (grant_now) begin
      state_d          = ST_BUSY;
      gnt_d            = '0;
      gnt_d[new_idx]   = 1'b1;
      idx_d            = new_idx;
      valid_d          = 1'b1;
      ptr_d            = new_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
      hold_d           = '0;
`endif
    end else if (drop_now) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

  idx_seg7 u_idx_seg7 (
    .idx   (idx_q),
    .valid (valid_q),
    .seg   (seg)
  );

endmodule
